refund_dispenser: RTL and testbench
===================================

Name: refund_dispenser

Overview:
- Back end of the vending datapath. Consumes the cola and change (half-unit) requests the coin-accepting FSM produces and drives the physical actuators.
- Queues requests, dispenses the cola first, then change as greedy one-yuan/half-yuan coins.
- Each actuator pulse is confirmed against a drop sensor, with a timeout that leads to a sticky fault.

Parameters:
- PULSE_CYC, 4: actuator fire pulse width in cycles (>=1).
- TIMEOUT_CYC, 1000: cycles allowed after a pulse ends for the sensor confirmation.
- DEPTH, 4: request queue depth (power of 2).
- AMT_W, 3: change amount width, in half-yuan units.

Ports:
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- req_valid, in, 1: request strobe.
- req_cola, in, 1: request includes one cola.
- req_money, in, AMT_W: change owed, in half-yuan units.
- req_ready, out, 1: request can be accepted.
- cola_fire, out, 1: cola actuator pulse.
- hop_one_fire, out, 1: one-yuan hopper pulse.
- hop_half_fire, out, 1: half-yuan hopper pulse.
- sense_cola, in, 1: cola drop sensor, single-cycle pulse.
- sense_coin, in, 1: coin drop sensor, single-cycle pulse, shared by both hoppers.
- done, out, 1: one-cycle pulse when a request completes.
- busy, out, 1: high while the queue is non-empty or the FSM is not in IDLE.
- fault, out, 1: sticky timeout indicator.
- fault_clr, in, 1: clears the fault.

Behaviour:
- Reset (async, sys_rst_n low):
  - All outputs 0 except req_ready=1.
  - Queue flushed, FSM to IDLE, counters 0.
  - Fire outputs drop immediately, including mid-pulse.
- Acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready = !full && state != FAULT.
  - Requests with req_cola=0 and req_money=0 are accepted but discarded: no queue entry, no done.
  - An enqueue and a dequeue in the same cycle are both honoured; occupancy is unchanged, including when the queue is full.
- FSM states: IDLE, LOAD, COLA_FIRE, COLA_WAIT, COIN_SEL, COIN_FIRE, COIN_WAIT, DONE, FAULT.
  - IDLE: queue non-empty -> LOAD.
  - LOAD: pop the head entry; latch rem=req_money and the cola flag. Flag set -> COLA_FIRE, else COIN_SEL.
  - COLA_FIRE: cola_fire=1 for exactly PULSE_CYC cycles, then COLA_WAIT.
  - COLA_WAIT: sense_cola -> COIN_SEL. Timeout counter reaches TIMEOUT_CYC -> FAULT.
  - COIN_SEL:
    - rem>=2: select the one-yuan hopper, rem-=2.
    - rem==1: select the half-yuan hopper, rem-=1.
    - rem==0: go to DONE.
    - rem is decremented on the COIN_SEL->COIN_FIRE transition.
  - COIN_FIRE: the selected hop_*_fire=1 for PULSE_CYC cycles, then COIN_WAIT.
  - COIN_WAIT: sense_coin -> COIN_SEL. Timeout -> FAULT.
  - DONE: done=1 for one cycle, then IDLE.
  - FAULT:
    - fault=1, all fire outputs 0, queue retained.
    - fault_clr -> IDLE. The in-flight request's remainder is discarded with no done; fault drops on the next cycle.
- Fire outputs are Moore: decoded from registered state. At most one fire output is high in any cycle.
- Sensor pulses count from the first fire cycle through the end of the matching WAIT state. A sense during FIRE is remembered, and WAIT then exits on its first cycle.
- Sensor pulses in any other state are ignored.
- Latency: with an empty queue and FSM in IDLE, the first fire goes high in the cycle beginning 2 edges after the accepting edge.
- The timeout counter starts at 0 on entry to each WAIT state. Wrap is impossible: the counter saturates at TIMEOUT_CYC.

Optional Feature:
- Macro: DISPENSE_RETRY_EN.
- Defined: the first timeout for a given item re-enters the same FIRE state, re-pulsing with the same selection and without further rem change. A second timeout on that item -> FAULT.
- Undefined: the first timeout -> FAULT.

Decomposition:
- Shared package/include refund_defs: one-hot state encodings (9 bits), COIN_ONE_UNITS=2, COIN_HALF_UNITS=1, request entry width AMT_W+1.
- Sub-module refund_req_fifo:
  - Synchronous FIFO, DEPTH entries of {cola, money}.
  - Ports: push, pop, full, empty, dout.
  - Async active-low reset.

Test Plan:
- PULSE_CYC=4; sensors answer 2 cycles after each pulse ends. Request cola=1, money=3 -> cola_fire x1, hop_one_fire x1, hop_half_fire x1, each 4 cycles wide, in that order; then one done pulse; busy falls the cycle after done.
- Request cola=0, money=4 -> exactly two hop_one_fire pulses, no hop_half_fire, no cola_fire, one done pulse.
- Five back-to-back requests while the first is dispensing -> req_ready low after the 4th queued entry; the 5th is held and accepted only after a pop. All five are served in FIFO order with five done pulses.
- No sense_coin after hop_one_fire -> fault=1 exactly TIMEOUT_CYC cycles after the pulse ends, req_ready=0, fires low. fault_clr -> IDLE, next queued request served, no done for the faulted request. With DISPENSE_RETRY_EN, a second pulse precedes the fault.
- Assert sys_rst_n low during the 2nd COIN_FIRE cycle -> hop_*_fire low immediately, busy=0, req_ready=1, no done; a previously queued request is not served after reset release.
- Request cola=0, money=0 -> no fire, no done, busy stays 0.

Source files
------------

// File: rtl/refund_defs_pkg.sv
// Shared definitions for the refund dispenser: one-hot FSM encoding, coin
// denominations and request entry width.
package refund_defs;

  localparam int STATE_W         = 9;
  localparam int COIN_ONE_UNITS  = 2;
  localparam int COIN_HALF_UNITS = 1;
  localparam int DEF_AMT_W       = 3;
  localparam int ENTRY_W         = DEF_AMT_W + 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 9'b0_0000_0001,
    ST_LOAD      = 9'b0_0000_0010,
    ST_COLA_FIRE = 9'b0_0000_0100,
    ST_COLA_WAIT = 9'b0_0000_1000,
    ST_COIN_SEL  = 9'b0_0001_0000,
    ST_COIN_FIRE = 9'b0_0010_0000,
    ST_COIN_WAIT = 9'b0_0100_0000,
    ST_DONE      = 9'b0_1000_0000,
    ST_FAULT     = 9'b1_0000_0000
  } state_t;

endpackage

// File: rtl/refund_dispenser_req_fifo.sv
// Request queue for the refund dispenser: DEPTH entries of {cola, money}.
module refund_req_fifo
  import refund_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  // An extra pointer bit separates full from empty when the indices match.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array, write port only
  always_ff @(posedge sys_clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/refund_dispenser.sv
// Refund dispenser: queues cola/change requests and drives actuators with
// drop-sensor confirmation. Optional macro DISPENSE_RETRY_EN re-pulses once on timeout.
module refund_dispenser
  import refund_defs::*;
#(
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int DEPTH       = 4,
  parameter int AMT_W       = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req_valid,
  input  logic             req_cola,
  input  logic [AMT_W-1:0] req_money,
  output logic             req_ready,
  output logic             cola_fire,
  output logic             hop_one_fire,
  output logic             hop_half_fire,
  input  logic             sense_cola,
  input  logic             sense_coin,
  output logic             done,
  output logic             busy,
  output logic             fault,
  input  logic             fault_clr
);

  localparam int EW = AMT_W + 1;
  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_CYC - 1);
  localparam logic [TW-1:0]    TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]    TMO_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [AMT_W-1:0] ONE_UNITS  = AMT_W'(COIN_ONE_UNITS);
  localparam logic [AMT_W-1:0] HALF_UNITS = AMT_W'(COIN_HALF_UNITS);

  state_t           state_r, state_s;
  logic [AMT_W-1:0] rem_r, rem_s;
  logic             sel_one_r, sel_one_s;
  logic [PW-1:0]    pulse_cnt_r, pulse_cnt_s;
  logic [TW-1:0]    wait_cnt_r, wait_cnt_s;
  logic             seen_r, seen_s;
  logic             retry_r, retry_s;
  logic             full_s, empty_s, push_s, pop_s;
  logic [EW-1:0]    head_s;

  // Empty requests are acknowledged but never occupy a queue slot.
  assign req_ready = !full_s && (state_r != ST_FAULT);
  assign push_s    = req_valid && req_ready && (req_cola || (req_money != {AMT_W{1'b0}}));

  refund_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .din       ({req_cola, req_money}),
    .full      (full_s),
    .empty     (empty_s),
    .dout      (head_s)
  );

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      rem_r       <= {AMT_W{1'b0}};
      sel_one_r   <= 1'b0;
      pulse_cnt_r <= {PW{1'b0}};
      wait_cnt_r  <= {TW{1'b0}};
      seen_r      <= 1'b0;
      retry_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      rem_r       <= rem_s;
      sel_one_r   <= sel_one_s;
      pulse_cnt_r <= pulse_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      seen_r      <= seen_s;
      retry_r     <= retry_s;
    end
  end

  // Next-state logic; counters and sense memory default to zero outside their states
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    sel_one_s   = sel_one_r;
    pulse_cnt_s = {PW{1'b0}};
    wait_cnt_s  = {TW{1'b0}};
    seen_s      = 1'b0;
    retry_s     = retry_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        retry_s = 1'b0;
        if (!empty_s) state_s = ST_LOAD;
        else          state_s = ST_IDLE;
      end
      ST_LOAD: begin
        pop_s   = 1'b1;
        retry_s = 1'b0;
        rem_s   = head_s[AMT_W-1:0];
        if (head_s[AMT_W]) state_s = ST_COLA_FIRE;
        else               state_s = ST_COIN_SEL;
      end
      ST_COLA_FIRE, ST_COIN_FIRE: begin
        seen_s = seen_r | ((state_r == ST_COLA_FIRE) ? sense_cola : sense_coin);
        if (pulse_cnt_r == PULSE_LAST) begin
          state_s = (state_r == ST_COLA_FIRE) ? ST_COLA_WAIT : ST_COIN_WAIT;
        end else begin
          pulse_cnt_s = pulse_cnt_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      ST_COLA_WAIT, ST_COIN_WAIT: begin
        if (seen_r || ((state_r == ST_COLA_WAIT) ? sense_cola : sense_coin)) begin
          state_s = ST_COIN_SEL;
          retry_s = 1'b0;
        end else if (wait_cnt_r == TMO_LAST) begin
`ifdef DISPENSE_RETRY_EN
          if (!retry_r) begin
            state_s = (state_r == ST_COLA_WAIT) ? ST_COLA_FIRE : ST_COIN_FIRE;
            retry_s = 1'b1;
          end else begin
            state_s = ST_FAULT;
          end
`else
          state_s = ST_FAULT;
`endif
        end else begin
          wait_cnt_s = (wait_cnt_r == TMO_MAX) ? wait_cnt_r : wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      ST_COIN_SEL: begin
        retry_s = 1'b0;
        if (rem_r >= ONE_UNITS) begin
          sel_one_s = 1'b1;
          rem_s     = rem_r - ONE_UNITS;
          state_s   = ST_COIN_FIRE;
        end else if (rem_r == HALF_UNITS) begin
          sel_one_s = 1'b0;
          rem_s     = rem_r - HALF_UNITS;
          state_s   = ST_COIN_FIRE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) state_s = ST_IDLE;
        else           state_s = ST_FAULT;
      end
      default:  state_s = ST_IDLE;
    endcase
  end

  // Moore decode from the state register keeps at most one actuator active.
  assign cola_fire     = (state_r == ST_COLA_FIRE);
  assign hop_one_fire  = (state_r == ST_COIN_FIRE) && sel_one_r;
  assign hop_half_fire = (state_r == ST_COIN_FIRE) && !sel_one_r;
  assign done          = (state_r == ST_DONE);
  assign fault         = (state_r == ST_FAULT);
  assign busy          = !empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_refund_dispenser.sv
// Directed bench for refund_dispenser: vector table plus hand-written corner sequences.
module tb_refund_dispenser;

  localparam int TMO = 1000;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n, req_valid, req_cola, fault_clr;
  logic [2:0] req_money;
  logic       sense_cola, sense_coin;
  logic       req_ready, cola_fire, hop_one_fire, hop_half_fire, done, busy, fault;

  refund_dispenser dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_cola(req_cola),
    .req_money(req_money), .req_ready(req_ready), .cola_fire(cola_fire),
    .hop_one_fire(hop_one_fire), .hop_half_fire(hop_half_fire), .sense_cola(sense_cola),
    .sense_coin(sense_coin), .done(done), .busy(busy), .fault(fault), .fault_clr(fault_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor and sensor model state
  int   cyc, n_cola, n_one, n_half, n_done, width_err, multi_err, last_done_cyc;
  int   run_len, seq_n, sdly;
  int   seq [64];
  logic p_cola, p_one, p_half, s_sel_cola;
  bit   auto_sense;

  always @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc <= 0; n_cola <= 0; n_one <= 0; n_half <= 0; n_done <= 0; width_err <= 0;
      multi_err <= 0; last_done_cyc <= -10; run_len <= 0; seq_n <= 0; sdly <= 0;
      p_cola <= 1'b0; p_one <= 1'b0; p_half <= 1'b0; s_sel_cola <= 1'b0;
      sense_cola <= 1'b0; sense_coin <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (done) begin n_done <= n_done + 1; last_done_cyc <= cyc; end
      if ($countones({cola_fire, hop_one_fire, hop_half_fire}) > 1) multi_err <= multi_err + 1;
      if (seq_n < 64) begin
        if (cola_fire && !p_cola) begin n_cola <= n_cola + 1; seq[seq_n] <= 1; seq_n <= seq_n + 1; end
        else if (hop_one_fire && !p_one) begin n_one <= n_one + 1; seq[seq_n] <= 2; seq_n <= seq_n + 1; end
        else if (hop_half_fire && !p_half) begin n_half <= n_half + 1; seq[seq_n] <= 3; seq_n <= seq_n + 1; end
      end
      if (cola_fire || hop_one_fire || hop_half_fire) run_len <= run_len + 1;
      else begin
        if ((p_cola || p_one || p_half) && run_len != 4) width_err <= width_err + 1;
        run_len <= 0;
      end
      // Sensor answers two cycles after each pulse ends
      sense_cola <= 1'b0;
      sense_coin <= 1'b0;
      if (auto_sense && ((p_cola && !cola_fire) || (p_one && !hop_one_fire) || (p_half && !hop_half_fire))) begin
        sdly <= 2; s_sel_cola <= p_cola;
      end else if (sdly == 1) begin
        if (s_sel_cola) sense_cola <= 1'b1;
        else            sense_coin <= 1'b1;
        sdly <= 0;
      end else if (sdly > 1) sdly <= sdly - 1;
      p_cola <= cola_fire; p_one <= hop_one_fire; p_half <= hop_half_fire;
    end
  end

  int total, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge; holds valid until an edge where ready is high
  task automatic send(input logic c, input logic [2:0] m, output bit ok);
    ok = 1'b0;
    req_cola = c; req_money = m;
    for (int n = 0; n < 3000 && !ok; n++) begin
      if (req_ready) begin
        req_valid = 1'b1;
        @(negedge sys_clk);
        req_valid = 1'b0;
        ok = 1'b1;
      end else @(negedge sys_clk);
    end
  endtask

  task automatic wait_idle(output bit ok, output int t);
    ok = 1'b0; t = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge sys_clk);
      if (!busy) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  typedef struct {
    logic       cola;
    logic [2:0] money;
    int         e_cola, e_one, e_half, e_done;
  } vec_t;

  vec_t vecs [6];
  int   exp5 [9];

  initial begin
    bit ok, busy_seen, found;
    int t, s_cola, s_one, s_half, s_done, s_werr, s_merr, s_seq, k, pulses, last_hi, f, exp_pulses;
    logic prev;

    vecs[0] = '{1'b1, 3'd3, 1, 1, 1, 1};
    vecs[1] = '{1'b0, 3'd4, 0, 2, 0, 1};
    vecs[2] = '{1'b0, 3'd0, 0, 0, 0, 0};
    vecs[3] = '{1'b0, 3'd7, 0, 3, 1, 1};
    vecs[4] = '{1'b1, 3'd0, 1, 0, 0, 1};
    vecs[5] = '{1'b0, 3'd1, 0, 0, 1, 1};
    exp5 = '{2, 2, 1, 3, 2, 1, 3, 2, 3};
    total = 0; bad = 0; auto_sense = 1'b1;

    sys_rst_n = 1'b0; req_valid = 1'b0; req_cola = 1'b0; req_money = 3'd0; fault_clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", req_ready, 1); chk("rst_busy", busy, 0); chk("rst_fault", fault, 0);
    chk("rst_done", done, 0);
    chk("rst_fires", {cola_fire, hop_one_fire, hop_half_fire}, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Latency: first fire in the cycle two edges after the accepting edge
    send(1'b1, 3'd0, ok);
    chk("lat_accept", ok, 1);
    chk("lat_e0", cola_fire, 0);
    @(negedge sys_clk); chk("lat_e1", cola_fire, 0);
    @(negedge sys_clk); chk("lat_e2", cola_fire, 1);
    wait_idle(ok, t); chk("lat_idle", ok, 1);
    @(negedge sys_clk);

    for (int v = 0; v < 6; v++) begin
      s_cola = n_cola; s_one = n_one; s_half = n_half; s_done = n_done;
      s_werr = width_err; s_merr = multi_err; s_seq = seq_n;
      send(vecs[v].cola, vecs[v].money, ok);
      chk($sformatf("v%0d_accept", v), ok, 1);
      if (vecs[v].e_done == 0) begin
        busy_seen = 1'b0;
        repeat (10) begin @(negedge sys_clk); if (busy) busy_seen = 1'b1; end
        chk($sformatf("v%0d_busy", v), busy_seen, 0);
      end else begin
        wait_idle(ok, t);
        chk($sformatf("v%0d_idle", v), ok, 1);
        chk($sformatf("v%0d_busy_fall", v), t, last_done_cyc + 1);
      end
      @(negedge sys_clk); @(negedge sys_clk);
      chk($sformatf("v%0d_cola", v), n_cola - s_cola, vecs[v].e_cola);
      chk($sformatf("v%0d_one", v), n_one - s_one, vecs[v].e_one);
      chk($sformatf("v%0d_half", v), n_half - s_half, vecs[v].e_half);
      chk($sformatf("v%0d_done", v), n_done - s_done, vecs[v].e_done);
      chk($sformatf("v%0d_width", v), width_err - s_werr, 0);
      chk($sformatf("v%0d_onehot", v), multi_err - s_merr, 0);
      chk($sformatf("v%0d_npulse", v), seq_n - s_seq, vecs[v].e_cola + vecs[v].e_one + vecs[v].e_half);
      k = s_seq;
      for (int i = 0; i < vecs[v].e_cola; i++) begin chk($sformatf("v%0d_order", v), seq[k], 1); k++; end
      for (int i = 0; i < vecs[v].e_one; i++)  begin chk($sformatf("v%0d_order", v), seq[k], 2); k++; end
      for (int i = 0; i < vecs[v].e_half; i++) begin chk($sformatf("v%0d_order", v), seq[k], 3); k++; end
    end

    // Queue full: one dispensing plus four queued, a fifth held until a pop
    s_done = n_done; s_seq = seq_n;
    send(1'b0, 3'd4, ok); chk("q_accept0", ok, 1);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (hop_one_fire) begin found = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk("q_dispensing", found, 1);
    send(1'b1, 3'd0, ok); chk("q_accept1", ok, 1);
    send(1'b0, 3'd1, ok); chk("q_accept2", ok, 1);
    send(1'b0, 3'd2, ok); chk("q_accept3", ok, 1);
    send(1'b1, 3'd1, ok); chk("q_accept4", ok, 1);
    chk("q_full_ready", req_ready, 0);
    send(1'b0, 3'd3, ok); chk("q_accept5", ok, 1);
    chk("q_held_until_pop", n_done - s_done, 1);
    wait_idle(ok, t); chk("q_idle", ok, 1);
    @(negedge sys_clk);
    chk("q_done", n_done - s_done, 6);
    chk("q_npulse", seq_n - s_seq, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("q_order%0d", i), seq[s_seq + i], exp5[i]);

    // Coin sensor silent: timeout leads to sticky fault
    auto_sense = 1'b0;
    s_done = n_done; s_cola = n_cola;
    send(1'b0, 3'd2, ok); chk("f_accept0", ok, 1);
    send(1'b1, 3'd0, ok); chk("f_accept1", ok, 1);
    found = 1'b0; pulses = 0; last_hi = 0; f = 0; prev = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (hop_one_fire) last_hi = i;
      if (hop_one_fire && !prev) pulses++;
      prev = hop_one_fire;
      if (fault) begin found = 1'b1; f = i; break; end
      @(negedge sys_clk);
    end
`ifdef DISPENSE_RETRY_EN
    exp_pulses = 2;
`else
    exp_pulses = 1;
`endif
    chk("f_seen", found, 1);
    chk("f_pulses", pulses, exp_pulses);
    chk("f_timing", f - last_hi, TMO + 1);
    chk("f_ready", req_ready, 0);
    chk("f_fires", {cola_fire, hop_one_fire, hop_half_fire}, 0);
    repeat (5) @(negedge sys_clk);
    chk("f_sticky", fault, 1);
    chk("f_busy", busy, 1);
    chk("f_queue_held", n_cola - s_cola, 0);
    fault_clr = 1'b1; auto_sense = 1'b1;
    @(negedge sys_clk);
    fault_clr = 1'b0;
    chk("f_clr", fault, 0);
    wait_idle(ok, t); chk("f_idle", ok, 1);
    @(negedge sys_clk);
    chk("f_done", n_done - s_done, 1);
    chk("f_next_served", n_cola - s_cola, 1);

    // Async reset during the second cycle of a coin pulse
    send(1'b0, 3'd2, ok); chk("r_accept0", ok, 1);
    send(1'b1, 3'd0, ok); chk("r_accept1", ok, 1);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (hop_one_fire) begin found = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk("r_firing", found, 1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("r_fires", {cola_fire, hop_one_fire, hop_half_fire}, 0);
    chk("r_busy", busy, 0);
    chk("r_ready", req_ready, 1);
    chk("r_done", done, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (40) begin @(negedge sys_clk); if (busy) busy_seen = 1'b1; end
    chk("r_not_served", n_cola + n_one + n_half, 0);
    chk("r_no_done", n_done, 0);
    chk("r_busy_after", busy_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
